// File: rtl/dispatch_queue_pkg.sv
// rtl/dispatch_queue_pkg.sv - shared types for the ID->OOO dispatch queue
//
// Purpose: the per-instruction dispatch entry (DQ_ENTRY), its sub-packets and
// the default queue geometry. The ID->OOO packet is N of these entries, slot 0
// oldest.
// Ports: none (package).
package dispatch_queue_pkg;

  localparam int DQ_N     = 2;   // default superscalar width
  localparam int DQ_DEPTH = 16;  // default queue depth

  typedef logic [$clog2(DQ_DEPTH)-1:0] dq_ptr_t;

  // Rename-table inputs for one slot
  typedef struct packed {
    logic       valid;
    logic [4:0] dest_reg;
    logic [4:0] src1_reg;
    logic [4:0] src2_reg;
  } rat_is_input_t;

  // Reorder-buffer entry for one slot
  typedef struct packed {
    logic        valid;
    logic [31:0] pc;
    logic [4:0]  dest_reg;
    logic        done;
  } rob_entry_t;

  // Reservation-station packet
  typedef struct packed {
    logic        valid;
    logic [31:0] pc;
    logic [6:0]  opcode;
    logic [11:0] imm;
  } id_rs_packet_t;

  // Store-queue packet
  typedef struct packed {
    logic       valid;
    logic       is_store;
    logic [1:0] size;
  } id_sq_packet_t;

  // One decoded instruction as packed by the decoder
  typedef struct packed {
    rat_is_input_t rat_is_input;
    rob_entry_t    rob_is_packet;
    id_rs_packet_t id_rs_packet;
    id_sq_packet_t id_sq_packet;
  } dq_entry_t;

endpackage

// File: rtl/dispatch_queue.sv
// rtl/dispatch_queue.sv - in-order N-wide circular dispatch queue, ID->OOO sender
//
// Purpose: accepts up to N decoded instructions per cycle and presents the
// oldest min(count, N) as the ID->OOO packet. The presented group retires as a
// whole when the core reports no structural hazard; squash empties the queue.
// Ports:
//   clock             in   sole clock, rising edge
//   reset             in   asynchronous active-low reset
//   squash            in   mispredict flush, empties queue at next edge
//   in_entries        in   N decoded entries, slot 0 oldest
//   in_valid          in   per-slot valid, contiguous from slot 0
//   structural_hazard in   core cannot take the presented packet this cycle
//   id_ooo_packet     out  N presented entries, absent slots all-zero
//   dq_stall          out  fewer than N free entries; decoder must hold
//   count_out         out  occupancy
module dispatch_queue
  import dispatch_queue_pkg::*;
#(
  parameter int N     = DQ_N,
  parameter int DEPTH = DQ_DEPTH
) (
  input  logic                         clock,
  input  logic                         reset,
  input  logic                         squash,
  input  dq_entry_t [N-1:0]            in_entries,
  input  logic [N-1:0]                 in_valid,
  input  logic                         structural_hazard,
  output dq_entry_t [N-1:0]            id_ooo_packet,
  output logic                         dq_stall,
  output logic [$clog2(DEPTH+1)-1:0]   count_out
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = $clog2(DEPTH+1);

  dq_entry_t        mem [DEPTH];
  logic [PTR_W-1:0] head;
  logic [PTR_W-1:0] tail;
  logic [CNT_W-1:0] count;

  logic [CNT_W-1:0] free_cnt;
  logic [CNT_W-1:0] present_cnt;
  logic [CNT_W-1:0] in_cnt;
  logic [CNT_W-1:0] enq_cnt;
  logic [CNT_W-1:0] deq_cnt;

  // Stall looks only at registered occupancy so the decoder handshake never
  // depends on this cycle's dequeue.
  assign free_cnt    = CNT_W'(DEPTH) - count;
  assign dq_stall    = free_cnt < CNT_W'(N);
  assign present_cnt = (count < CNT_W'(N)) ? count : CNT_W'(N);
  assign count_out   = count;

  always_comb begin
    in_cnt = '0;
    for (int j = 0; j < N; j++) begin
      in_cnt = in_cnt + CNT_W'(in_valid[j]);
    end
  end

  // The core takes every presented slot or none.
  assign enq_cnt = dq_stall ? '0 : in_cnt;
  assign deq_cnt = structural_hazard ? '0 : present_cnt;

  // Presentation is driven from registered state only; empty slots are zeroed
  // so every valid flag inside them reads 0.
  always_comb begin
    for (int i = 0; i < N; i++) begin
      id_ooo_packet[i] = '0;
      if (CNT_W'(i) < count) begin
        id_ooo_packet[i] = mem[head + PTR_W'(i)];
      end
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      head  <= '0;
      tail  <= '0;
      count <= '0;
    end else if (squash) begin
      head  <= '0;
      tail  <= '0;
      count <= '0;
    end else begin
      head  <= head + PTR_W'(deq_cnt);
      tail  <= tail + PTR_W'(enq_cnt);
      count <= count + enq_cnt - deq_cnt;
    end
  end

  // Storage contents are don't-care after reset, so no reset branch here.
  always_ff @(posedge clock) begin
    if (!squash && !dq_stall) begin
      for (int j = 0; j < N; j++) begin
        if (in_valid[j]) begin
          mem[tail + PTR_W'(j)] <= in_entries[j];
        end
      end
    end
  end

endmodule

// File: tb/tb_dispatch_queue.sv
// tb/tb_dispatch_queue.sv - directed self-checking bench for dispatch_queue
//
// Purpose: drives the queue with N=2, DEPTH=8 through fill, hazard hold, stall,
// wrap-around, squash and asynchronous reset, comparing against hand-computed
// expectations.
// Ports: none (top-level bench).
module tb_dispatch_queue;
  import dispatch_queue_pkg::*;

  logic               clock;
  logic               reset;
  logic               squash;
  dq_entry_t [1:0]    in_entries;
  logic [1:0]         in_valid;
  logic               structural_hazard;
  dq_entry_t [1:0]    id_ooo_packet;
  logic               dq_stall;
  logic [3:0]         count_out;

  int n_cmp = 0;
  int n_err = 0;

  dispatch_queue #(.N(2), .DEPTH(8)) dut (
    .clock             (clock),
    .reset             (reset),
    .squash            (squash),
    .in_entries        (in_entries),
    .in_valid          (in_valid),
    .structural_hazard (structural_hazard),
    .id_ooo_packet     (id_ooo_packet),
    .dq_stall          (dq_stall),
    .count_out         (count_out)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  function automatic dq_entry_t mk(input logic [31:0] pc);
    dq_entry_t e;
    e = '0;
    e.rat_is_input.valid    = 1'b1;
    e.rat_is_input.dest_reg = pc[6:2];
    e.rob_is_packet.valid   = 1'b1;
    e.rob_is_packet.pc      = pc;
    e.rob_is_packet.dest_reg = pc[6:2];
    e.id_rs_packet.valid    = 1'b1;
    e.id_rs_packet.pc       = pc;
    e.id_rs_packet.opcode   = 7'h13;
    e.id_sq_packet.valid    = 1'b1;
    return e;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Advance one edge and settle just after it.
  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic drive(input logic [1:0] v, input logic [31:0] pc0, input logic [31:0] pc1);
    in_valid      = v;
    in_entries[0] = mk(pc0);
    in_entries[1] = mk(pc1);
  endtask

  function automatic logic [31:0] vld();
    return {28'd0, id_ooo_packet[1].id_sq_packet.valid & id_ooo_packet[1].rat_is_input.valid,
            id_ooo_packet[0].id_sq_packet.valid & id_ooo_packet[0].rat_is_input.valid,
            id_ooo_packet[1].rob_is_packet.valid, id_ooo_packet[0].rob_is_packet.valid};
  endfunction

  function automatic logic [31:0] pkt_zero();
    return {31'd0, id_ooo_packet == '0};
  endfunction

  initial begin
    reset = 1'b0;
    squash = 1'b0;
    structural_hazard = 1'b0;
    drive(2'b00, 32'h0, 32'h0);

    #12;
    chk("rst_count", 32'(count_out), 32'd0);
    chk("rst_stall", 32'(dq_stall), 32'd0);
    chk("rst_pkt_zero", pkt_zero(), 32'd1);
    reset = 1'b1;

    // 1: enqueue pair, presented next cycle, drained the cycle after
    drive(2'b11, 32'h0, 32'h4);
    step();
    drive(2'b00, 32'h0, 32'h0);
    chk("s1_count", 32'(count_out), 32'd2);
    chk("s1_pc0", id_ooo_packet[0].rob_is_packet.pc, 32'h0);
    chk("s1_pc1", id_ooo_packet[1].rob_is_packet.pc, 32'h4);
    chk("s1_valid", vld(), 32'hF);
    step();
    chk("s1_empty_count", 32'(count_out), 32'd0);
    chk("s1_empty_pkt", pkt_zero(), 32'd1);

    // 2: one per cycle under hazard, then release
    structural_hazard = 1'b1;
    drive(2'b01, 32'h8, 32'h0);
    step();
    chk("s2_c1", 32'(count_out), 32'd1);
    chk("s2_valid1", vld(), 32'h5);
    drive(2'b01, 32'hC, 32'h0);
    step();
    chk("s2_c2", 32'(count_out), 32'd2);
    drive(2'b01, 32'h10, 32'h0);
    step();
    chk("s2_c3", 32'(count_out), 32'd3);
    chk("s2_hold_pc0", id_ooo_packet[0].rob_is_packet.pc, 32'h8);
    chk("s2_hold_pc1", id_ooo_packet[1].rob_is_packet.pc, 32'hC);
    structural_hazard = 1'b0;
    drive(2'b01, 32'h14, 32'h0);
    step();
    chk("s2_after_count", 32'(count_out), 32'd2);
    chk("s2_after_pc0", id_ooo_packet[0].rob_is_packet.pc, 32'h10);
    chk("s2_after_pc1", id_ooo_packet[1].rob_is_packet.pc, 32'h14);
    drive(2'b00, 32'h0, 32'h0);
    step();
    chk("s2_drain", 32'(count_out), 32'd0);

    // Move head/tail from 6 to 7 with a single in-and-out
    drive(2'b01, 32'h40, 32'h0);
    step();
    chk("adv_count", 32'(count_out), 32'd1);
    drive(2'b00, 32'h0, 32'h0);
    step();
    chk("adv_empty", pkt_zero(), 32'd1);

    // 3: fill to 7 under hazard; pair at head straddles index 7 -> 0
    structural_hazard = 1'b1;
    drive(2'b11, 32'h100, 32'h104);
    step();
    drive(2'b11, 32'h108, 32'h10C);
    step();
    drive(2'b11, 32'h110, 32'h114);
    step();
    chk("s3_c6", 32'(count_out), 32'd6);
    chk("s3_c6_stall", 32'(dq_stall), 32'd0);
    drive(2'b01, 32'h118, 32'h0);
    step();
    chk("s3_c7", 32'(count_out), 32'd7);
    chk("s3_stall", 32'(dq_stall), 32'd1);
    drive(2'b11, 32'h200, 32'h204);
    step();
    chk("s3_ignored", 32'(count_out), 32'd7);
    chk("s3_stall_hold", 32'(dq_stall), 32'd1);

    // 4: wrap-around presentation (slot 0 = index 7, slot 1 = index 0)
    chk("s4_pc0", id_ooo_packet[0].rob_is_packet.pc, 32'h100);
    chk("s4_pc1", id_ooo_packet[1].rob_is_packet.pc, 32'h104);
    structural_hazard = 1'b0;
    drive(2'b00, 32'h0, 32'h0);
    step();
    chk("s4_deq_count", 32'(count_out), 32'd5);
    chk("s4_deq_pc0", id_ooo_packet[0].rob_is_packet.pc, 32'h108);
    chk("s4_unstall", 32'(dq_stall), 32'd0);

    // 5: squash with count 5 while enqueuing 2
    squash = 1'b1;
    drive(2'b11, 32'h300, 32'h304);
    #1;
    chk("s5_pkt_during", id_ooo_packet[0].rob_is_packet.pc, 32'h108);
    step();
    squash = 1'b0;
    drive(2'b00, 32'h0, 32'h0);
    chk("s5_count", 32'(count_out), 32'd0);
    chk("s5_pkt_zero", pkt_zero(), 32'd1);
    step();
    chk("s5_lost", 32'(count_out), 32'd0);

    // 6: asynchronous reset between edges with count 4
    structural_hazard = 1'b1;
    drive(2'b11, 32'h500, 32'h504);
    step();
    drive(2'b11, 32'h508, 32'h50C);
    step();
    drive(2'b00, 32'h0, 32'h0);
    chk("s6_pre_count", 32'(count_out), 32'd4);
    #2;
    reset = 1'b0;
    #1;
    chk("s6_async_count", 32'(count_out), 32'd0);
    chk("s6_async_pkt", pkt_zero(), 32'd1);
    chk("s6_async_stall", 32'(dq_stall), 32'd0);
    #2;
    reset = 1'b1;
    structural_hazard = 1'b0;
    drive(2'b11, 32'h600, 32'h604);
    step();
    drive(2'b00, 32'h0, 32'h0);
    chk("s6_resume_count", 32'(count_out), 32'd2);
    chk("s6_resume_pc0", id_ooo_packet[0].rob_is_packet.pc, 32'h600);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/dispatch_queue.md
# dispatch_queue

In-order, N-wide circular buffer between the decoder and the out-of-order core. It is the sending side of the ID→OOO interface. Each cycle it accepts up to N decoded instructions and presents the oldest up to N as an `ID_OOO_PACKET`. It retires the presented group only when the core reports no `structural_hazard`, and discards all contents on `squash`.

## Interface
- `N`, default `` `N ``: superscalar width, i.e. slots per enqueue/dequeue.
- `DEPTH`, default 16: entry count; power of two, ≥ 2·N.
- `clock`  in  1  sole clock; all state updates on rising edge.
- `reset`  in  1  asynchronous, active-low (asserted when 0); clears all state immediately.
- `squash`  in  1  core mispredict flush.
- `in_entries`  in  N×`DQ_ENTRY`  decoded instructions; slot 0 is oldest.
- `in_valid`  in  N  per-slot valid; must be contiguous from slot 0.
- `structural_hazard`  in  1  core cannot accept the presented packet this cycle.
- `id_ooo_packet`  out  `ID_OOO_PACKET`  oldest min(count, N) entries, all valid flags gated.
- `dq_stall`  out  1  decoder must hold; true when free slots < N.
- `count_out`  out  $clog2(DEPTH+1)  occupancy, for debug.

## Operation
- State: `DEPTH` entries, `head` and `tail` pointers of width log2(DEPTH), and `count`.
- Present:
  - Slot i (0 ≤ i < N) shows entry `(head+i) mod DEPTH` when i < count.
  - Otherwise slot i is all-zero with every valid flag 0: `id_rs_packet`, `id_sq_packet`, `rob_is_packet.valid`, `rat_is_input` valid.
- `deq` = number of presented valid slots when `structural_hazard`=0; else 0. The core takes all presented slots or none.
- `enq` = popcount(`in_valid`) when `dq_stall`=0; else 0. With `dq_stall`=1, input is ignored.
- Update:
  - `head += deq`, `tail += enq`, both modulo DEPTH.
  - `count += enq − deq`.
  - Slot j is written to `(tail+j) mod DEPTH`.
- `dq_stall` = (DEPTH − count) < N. It uses registered count only; same-cycle dequeue is not credited.
- `squash`:
  - Next state is `head=tail=count=0`.
  - Same-cycle enqueue and dequeue are dropped.
  - `id_ooo_packet` is still driven from current state during the squash cycle. The core ignores it because the core is resetting.
- Empty: packet fully invalid, `deq`=0.
- Full: `dq_stall`=1, and dequeue proceeds normally.
- Wrap-around: groups that straddle index DEPTH−1→0 are presented and written contiguously in order.

## Timing
- Reset values:
  - `count_out`=0 and `dq_stall`=0.
  - `id_ooo_packet` is all-zero (no valid).
  - Entry storage contents are don't-care.
- Latency: an instruction enqueued at edge t is presented in the cycle after edge t. There is no input→output bypass, so `id_ooo_packet` is purely registered-state driven. This prevents a loop through `structural_hazard`.
- Only `deq` depends combinationally on `structural_hazard`, and only into next-state logic.
- Reset mid-operation: takes effect asynchronously. Outputs go invalid without waiting for a clock edge.
- Simultaneous `squash` and `reset`: reset dominates.

## Structure
- `DQ_ENTRY` belongs in `sys_defs.svh`. It is the per-instruction slice of `ID_OOO_PACKET`:
  - `RAT_IS_INPUT` fields for one slot
  - `ROB_ENTRY` for one slot
  - `ID_RS_PACKET`
  - `ID_SQ_PACKET`
- A `DQ_PTR` typedef also belongs in `sys_defs.svh`.
- The decoder packs `DQ_ENTRY`. This block unpacks entries into `ID_OOO_PACKET` slot positions.
- No sub-module: pointer arithmetic, storage array and the slot mux sit in one module.

## Test plan
All scenarios use N=2, DEPTH=8.
1. Reset 0→1, then enqueue 2 entries (PC 0x0, 0x4), with `structural_hazard`=0.
   - Next cycle: slots 0/1 show PC 0x0/0x4, valid=2'b11.
   - Following cycle: empty, all valid 0.
2. Enqueue 1 entry per cycle while `structural_hazard`=1 for 3 cycles.
   - Packet content holds steady.
   - `count_out` rises to 3.
   - After hazard drops: the 2 oldest leave, and `count_out` becomes 1 plus new enqueues.
3. Fill to 7 entries.
   - `dq_stall`=1 and `in_valid`=2'b11 is ignored; `count_out` stays 7 while hazard is held.
4. Wrap-around: cycle head to index 7 and enqueue 2.
   - Slot 0 reads index 7 and slot 1 reads index 0.
   - PC order is preserved.
5. `squash` with `count_out`=5 while enqueuing 2.
   - Next cycle `count_out`=0 and the packet is invalid.
   - The enqueued pair is lost.
6. Assert `reset`=0 asynchronously between edges with `count_out`=4.
   - Outputs go invalid before the next edge.
   - `count_out`=0.
